// File: rtl/mcu_multi_cycle_ctrl.sv
// Multi-cycle MCU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB/HALT and decodes datapath strobes.
// Latency: JMP 2, BEQ 3, R-type/ADDI 4, SW 4+w, LW 5+w cycles (w = MEM cycles with mem_ready low).
// Backpressure: MEM holds MemRead/MemWrite and stalls until mem_ready; HALT stalls until Clear.
// Ports: clk, Clear (async, active-high); opcode/zero/mem_ready from datapath and memory;
//   PCWrite/IRWrite/RegWrite strobes, RegDst/Jump/Branch/MemToReg/ALUsrc selects,
//   MemRead/MemWrite, ALUop, state, halted, illegal, instr_count (retired instructions).
module mcu_multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             Jump,
  output logic             Branch,
  output logic             MemToReg,
  output logic             ALUsrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       ALUop,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pcw_c, irw_c, rw_c, rd_c, jmp_c, br_c, m2r_c, asrc_c, mr_c, mw_c;
  logic halted_c, illegal_c, retire_c;
  logic [2:0] aluop_c;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= 4'h4;
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    return is_rtype(op) || op == OP_ADDI || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_JMP || op == OP_HALT;
  endfunction

  always_comb begin
    pcw_c     = 1'b0;
    irw_c     = 1'b0;
    rw_c      = 1'b0;
    rd_c      = 1'b0;
    jmp_c     = 1'b0;
    br_c      = 1'b0;
    m2r_c     = 1'b0;
    asrc_c    = 1'b0;
    mr_c      = 1'b0;
    mw_c      = 1'b0;
    aluop_c   = 3'b000;
    halted_c  = 1'b0;
    illegal_c = 1'b0;
    retire_c  = 1'b0;
    op_d      = op_q;
    state_d   = S_FETCH;
    case (state_q)
      S_FETCH: begin
        irw_c   = 1'b1;
        pcw_c   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // op_q is not yet valid here, so this state decodes the live opcode.
        op_d = opcode;
        if (opcode == OP_JMP) begin
          jmp_c    = 1'b1;
          pcw_c    = 1'b1;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (opcode == OP_HALT) begin
          retire_c = 1'b1;
          state_d  = S_HALT;
        end else if (is_defined(opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_rtype(op_q)) begin
          aluop_c = op_q[2:0];
          state_d = S_WB;
        end else if (op_q == OP_ADDI) begin
          asrc_c  = 1'b1;
          state_d = S_WB;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          asrc_c  = 1'b1;
          state_d = S_MEM;
        end else if (op_q == OP_BEQ) begin
          aluop_c  = 3'b001;
          br_c     = 1'b1;
          pcw_c    = zero;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        if (op_q == OP_LW) begin
          mr_c    = 1'b1;
          state_d = mem_ready ? S_WB : S_MEM;
        end else if (op_q == OP_SW) begin
          mw_c     = 1'b1;
          retire_c = mem_ready;
          state_d  = mem_ready ? S_FETCH : S_MEM;
        end
      end
      S_WB: begin
        rw_c     = 1'b1;
        rd_c     = is_rtype(op_q);
        m2r_c    = (op_q == OP_LW);
        retire_c = 1'b1;
      end
      S_HALT: begin
        halted_c = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q <= S_FETCH;
      op_q    <= 4'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset state is FETCH, whose strobes would otherwise be live; Clear masks
  // every output combinationally so strobes drop without waiting for an edge.
  assign PCWrite     = pcw_c     & ~Clear;
  assign IRWrite     = irw_c     & ~Clear;
  assign RegWrite    = rw_c      & ~Clear;
  assign RegDst      = rd_c      & ~Clear;
  assign Jump        = jmp_c     & ~Clear;
  assign Branch      = br_c      & ~Clear;
  assign MemToReg    = m2r_c     & ~Clear;
  assign ALUsrc      = asrc_c    & ~Clear;
  assign MemRead     = mr_c      & ~Clear;
  assign MemWrite    = mw_c      & ~Clear;
  assign ALUop       = aluop_c   & {3{~Clear}};
  assign halted      = halted_c  & ~Clear;
  assign illegal     = illegal_c & ~Clear;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mcu_multi_cycle_ctrl.sv
// Self-checking bench for mcu_multi_cycle_ctrl with a per-cycle expected-output scoreboard.
// Latency: not applicable (testbench).
// Backpressure: drives mem_ready low for chosen MEM cycles to exercise stalls.
module tb_mcu_multi_cycle_ctrl;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          Clear = 1'b1;
  logic [3:0]    opcode = 4'h0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, IRWrite, RegWrite, RegDst, Jump, Branch, MemToReg, ALUsrc;
  logic          MemRead, MemWrite, halted, illegal;
  logic [2:0]    ALUop, state;
  logic [CW-1:0] instr_count;

  mcu_multi_cycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .Clear(Clear), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .Jump(Jump), .Branch(Branch), .MemToReg(MemToReg), .ALUsrc(ALUsrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUop(ALUop), .state(state),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Control vector bit order: PCW IRW RW RD JP BR M2R ASRC MR MW
  localparam logic [9:0] PCW  = 10'b10_0000_0000;
  localparam logic [9:0] IRW  = 10'b01_0000_0000;
  localparam logic [9:0] RW   = 10'b00_1000_0000;
  localparam logic [9:0] RD   = 10'b00_0100_0000;
  localparam logic [9:0] JP   = 10'b00_0010_0000;
  localparam logic [9:0] BR   = 10'b00_0001_0000;
  localparam logic [9:0] M2R  = 10'b00_0000_1000;
  localparam logic [9:0] ASRC = 10'b00_0000_0100;
  localparam logic [9:0] MR   = 10'b00_0000_0010;
  localparam logic [9:0] MW   = 10'b00_0000_0001;

  logic [17:0]   exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {state, halted, illegal, ALUop, PCWrite, IRWrite, RegWrite, RegDst, Jump,
            Branch, MemToReg, ALUsrc, MemRead, MemWrite};
  endfunction

  function automatic logic [17:0] mk(input logic [2:0] st, input logic [9:0] ctl,
                                     input logic [2:0] alu, input logic h, input logic il);
    return {st, h, il, alu, ctl};
  endfunction

  // One clock cycle: expectation queued with the stimulus, compared mid-cycle.
  task automatic cycle(input string tag, input logic [17:0] e, input logic mr);
    logic [17:0] want;
    mem_ready = mr;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check(tag, 32'(obs()), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic z, input int w);
    opcode = op;
    zero   = z;
    cycle("fetch", mk(3'd0, PCW | IRW, 3'b000, 1'b0, 1'b0), 1'b0);
    if (op == 4'hC) begin
      cycle("jmp_dec", mk(3'd1, JP | PCW, 3'b000, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
    end else if (op == 4'hF) begin
      cycle("halt_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
      for (int i = 0; i < 20; i++)
        cycle("halt_hold", mk(3'd5, 10'b0, 3'b000, 1'b1, 1'b0), 1'b0);
    end else if (op <= 4'h4) begin
      cycle("r_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
      cycle("r_exec", mk(3'd2, 10'b0, op[2:0], 1'b0, 1'b0), 1'b0);
      cycle("r_wb", mk(3'd4, RW | RD, 3'b000, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
    end else if (op == 4'h5) begin
      cycle("addi_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
      cycle("addi_exec", mk(3'd2, ASRC, 3'b000, 1'b0, 1'b0), 1'b0);
      cycle("addi_wb", mk(3'd4, RW, 3'b000, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
    end else if (op == 4'h8 || op == 4'h9) begin
      cycle("ls_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
      cycle("ls_exec", mk(3'd2, ASRC, 3'b000, 1'b0, 1'b0), 1'b0);
      for (int i = 0; i <= w; i++)
        cycle("ls_mem", mk(3'd3, (op == 4'h8) ? MR : MW, 3'b000, 1'b0, 1'b0), i == w);
      if (op == 4'h8)
        cycle("lw_wb", mk(3'd4, RW | M2R, 3'b000, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
    end else if (op == 4'hA) begin
      cycle("beq_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
      cycle("beq_exec", mk(3'd2, BR | (z ? PCW : 10'b0), 3'b001, 1'b0, 1'b0), 1'b0);
      exp_cnt++;
    end else begin
      cycle("ill_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b1), 1'b0);
    end
    check("instr_count", 32'(instr_count), 32'(exp_cnt));
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    #1;
    check("clr_outputs", 32'(obs()), 32'h0);
    check("clr_count", 32'(instr_count), 32'h0);
    @(posedge clk);
    #1;
    check("clr_hold", 32'(obs()), 32'h0);
    Clear = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    // Held in reset from time 0.
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'(obs()), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    Clear = 1'b0;

    run(4'h0, 1'b0, 0);   // ADD
    run(4'h1, 1'b0, 0);   // SUB
    run(4'h4, 1'b0, 0);   // XOR
    run(4'h5, 1'b0, 0);   // ADDI
    run(4'h8, 1'b0, 3);   // LW with 3 stall cycles
    run(4'h9, 1'b0, 1);   // SW with 1 stall cycle
    run(4'h9, 1'b0, 0);   // SW, no stall
    run(4'hA, 1'b1, 0);   // BEQ taken
    run(4'hA, 1'b0, 0);   // BEQ not taken
    run(4'h6, 1'b0, 0);   // undefined
    run(4'hB, 1'b0, 0);   // undefined
    run(4'hC, 1'b0, 0);   // JMP
    run(4'hF, 1'b0, 0);   // HALT, held 20 cycles
    check("halt_count_steady", 32'(instr_count), 32'(exp_cnt));
    pulse_clear();

    // Fill the counter to all-ones, then one more retirement wraps it.
    for (int i = 0; i < (1 << CW) - 1; i++) run(4'hC, 1'b0, 0);
    check("cnt_full", 32'(instr_count), 32'((1 << CW) - 1));
    run(4'hC, 1'b0, 0);
    check("cnt_wrap", 32'(instr_count), 32'h0);

    // Clear while SW is stalled in MEM: MemWrite must drop before the next edge.
    opcode = 4'h9;
    cycle("sw_fetch", mk(3'd0, PCW | IRW, 3'b000, 1'b0, 1'b0), 1'b0);
    cycle("sw_dec", mk(3'd1, 10'b0, 3'b000, 1'b0, 1'b0), 1'b0);
    cycle("sw_exec", mk(3'd2, ASRC, 3'b000, 1'b0, 1'b0), 1'b0);
    mem_ready = 1'b0;
    check("sw_mem_strobe", 32'(MemWrite), 32'h1);
    #2;
    Clear = 1'b1;
    #1;
    check("sw_clr_memwrite", 32'(MemWrite), 32'h0);
    check("sw_clr_outputs", 32'(obs()), 32'h0);
    @(posedge clk);
    #1;
    Clear = 1'b0;
    exp_cnt = '0;
    run(4'h0, 1'b0, 0);   // first instruction after Clear starts in FETCH

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
